// File: rtl/pool_ctrl_pkg.sv
// Shared types and helpers for the 2x2 pooling frame sequencer.
package pool_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE,
        SOF,
        ACC0,
        ACC1,
        ISS0,
        ISS1,
        GAP,
        SOL,
        EOF
    } state_t;

    localparam int unsigned GAP_CYC_DEF = 2;
    localparam int unsigned GAP_W       = 4;

    // Frame dimensions must be even so every 2x2 window is complete.
    function automatic logic cfg_ok(input int unsigned width,
                                    input int unsigned height,
                                    input int unsigned max_w,
                                    input int unsigned max_h);
        return (width[0] == 1'b0) && (width >= 2) && (width <= max_w) &&
               (height[0] == 1'b0) && (height >= 2) && (height <= max_h);
    endfunction

endpackage

// File: rtl/pool_frame_sequencer_if.sv
// Upstream valid/ready pixel stream feeding the pooling sequencer.
interface pool_frame_sequencer_if #(
    parameter int unsigned DATA_W = 16
) ();
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/pool_pair_buf.sv
// Two-entry column-pair buffer: fills slot 0/1 on accept, presents one slot for issue.
module pool_pair_buf #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_sel,
    output logic [DATA_W-1:0] rd_data_c
);
    logic [DATA_W-1:0] pair0;
    logic [DATA_W-1:0] pair1;

    // Clear wins over a same-cycle write so an aborted pixel is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            pair0 <= '0;
            pair1 <= '0;
        end else if (wr_en) begin
            if (wr_sel) begin
                pair1 <= wr_data;
            end else begin
                pair0 <= wr_data;
            end
        end
    end

    assign rd_data_c = rd_sel ? pair1 : pair0;

endmodule

// File: rtl/pool_frame_sequencer.sv
// Turns a valid/ready pixel stream into ena/frame/line control for the 2x2 max-pool
// datapath, issuing pixels as back-to-back column pairs with drain gaps per line.
module pool_frame_sequencer
    import pool_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned MAX_W   = 32,
    parameter int unsigned MAX_H   = 1024,
    parameter int unsigned GAP_CYC = GAP_CYC_DEF,
    parameter int unsigned CW      = $clog2(MAX_W + 1),
    parameter int unsigned RW      = $clog2(MAX_H + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [CW-1:0]          cfg_width,
    input  logic [RW-1:0]          cfg_height,
    pool_frame_sequencer_if.slave  up,
    output logic                   pool_ena,
    output logic [DATA_W-1:0]      pool_data,
    output logic                   pool_frame_start,
    output logic                   pool_line_start,
    output logic                   pool_frame_end,
    output logic                   busy,
    output logic                   done,
    output logic                   cfg_err
);

    state_t            state;
    logic [CW-1:0]     col;
    logic [CW-1:0]     width_q;
    logic [RW-1:0]     row;
    logic [RW-1:0]     height_q;
    logic [GAP_W-1:0]  gap;

    logic              hs;
    logic              kill;
    logic [CW-1:0]     col_next;
    logic [DATA_W-1:0] rd_data_c;

    assign up.s_ready = (state == ACC0) || (state == ACC1);
    assign hs         = up.s_valid && up.s_ready;
    assign kill       = abort && (state != IDLE) && (state != EOF);
    assign col_next   = CW'(col + CW'(2));

    // Slot 0 feeds ISS0, slot 1 feeds ISS1; the read is taken one state early.
    pool_pair_buf #(
        .DATA_W (DATA_W)
    ) u_pair_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (kill),
        .wr_en     (hs && !abort),
        .wr_sel    (state == ACC1),
        .wr_data   (up.s_data),
        .rd_sel    (state == ISS0),
        .rd_data_c (rd_data_c)
    );

    // Outputs are set on the edge entering the state they belong to.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= IDLE;
            col              <= '0;
            row              <= '0;
            gap              <= '0;
            width_q          <= '0;
            height_q         <= '0;
            pool_ena         <= 1'b0;
            pool_data        <= '0;
            pool_frame_start <= 1'b0;
            pool_line_start  <= 1'b0;
            pool_frame_end   <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            cfg_err          <= 1'b0;
        end else begin
            pool_ena         <= 1'b0;
            pool_frame_start <= 1'b0;
            pool_line_start  <= 1'b0;
            pool_frame_end   <= 1'b0;
            done             <= 1'b0;
            cfg_err          <= 1'b0;

            if (kill) begin
                state          <= EOF;
                pool_frame_end <= 1'b1;
                col            <= '0;
                gap            <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (cfg_ok(32'(cfg_width), 32'(cfg_height), MAX_W, MAX_H)) begin
                                width_q          <= cfg_width;
                                height_q         <= cfg_height;
                                state            <= SOF;
                                pool_frame_start <= 1'b1;
                                pool_line_start  <= 1'b1;
                                busy             <= 1'b1;
                            end else begin
                                cfg_err <= 1'b1;
                            end
                        end
                    end
                    SOF: begin
                        col   <= '0;
                        row   <= '0;
                        state <= ACC0;
                    end
                    ACC0: begin
                        if (hs) begin
                            state <= ACC1;
                        end
                    end
                    ACC1: begin
                        if (hs) begin
                            state     <= ISS0;
                            pool_ena  <= 1'b1;
                            pool_data <= rd_data_c;
                        end
                    end
                    ISS0: begin
                        state     <= ISS1;
                        pool_ena  <= 1'b1;
                        pool_data <= rd_data_c;
                    end
                    ISS1: begin
                        if (col_next == width_q) begin
                            col   <= '0;
                            gap   <= '0;
                            state <= GAP;
                        end else begin
                            col   <= col_next;
                            state <= ACC0;
                        end
                    end
                    GAP: begin
                        if (gap == GAP_W'(GAP_CYC - 1)) begin
                            gap <= '0;
                            if (row == RW'(height_q - RW'(1))) begin
                                state          <= EOF;
                                pool_frame_end <= 1'b1;
                                done           <= 1'b1;
                            end else begin
                                state           <= SOL;
                                pool_line_start <= 1'b1;
                            end
                        end else begin
                            gap <= GAP_W'(gap + GAP_W'(1));
                        end
                    end
                    SOL: begin
                        row   <= RW'(row + RW'(1));
                        state <= ACC0;
                    end
                    EOF: begin
                        row   <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pool_frame_sequencer.sv
// Scoreboard bench for pool_frame_sequencer: a driver queues expected pixels on
// handshake, a negedge monitor checks pool_data order, pair adjacency and pulse exclusivity.
module tb_pool_frame_sequencer;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned MAX_W   = 32;
    localparam int unsigned MAX_H   = 32;
    localparam int unsigned GAP_CYC = 2;
    localparam int unsigned CW      = $clog2(MAX_W + 1);
    localparam int unsigned RW      = $clog2(MAX_H + 1);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [CW-1:0]     cfg_width = '0;
    logic [RW-1:0]     cfg_height = '0;
    logic              pool_ena;
    logic [DATA_W-1:0] pool_data;
    logic              pool_frame_start;
    logic              pool_line_start;
    logic              pool_frame_end;
    logic              busy;
    logic              done;
    logic              cfg_err;

    pool_frame_sequencer_if #(.DATA_W(DATA_W)) up ();

    pool_frame_sequencer #(
        .DATA_W  (DATA_W),
        .MAX_W   (MAX_W),
        .MAX_H   (MAX_H),
        .GAP_CYC (GAP_CYC)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .abort            (abort),
        .cfg_width        (cfg_width),
        .cfg_height       (cfg_height),
        .up               (up),
        .pool_ena         (pool_ena),
        .pool_data        (pool_data),
        .pool_frame_start (pool_frame_start),
        .pool_line_start  (pool_line_start),
        .pool_frame_end   (pool_frame_end),
        .busy             (busy),
        .done             (done),
        .cfg_err          (cfg_err)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;
    int exp_q[$];
    int pix_id = 1;

    int cyc = 0, run = 0;
    int ena_cnt = 0, ls_cnt = 0, fs_cnt = 0, fe_cnt = 0, done_cnt = 0, err_cnt = 0;
    int fs_cyc = 0, fe_cyc = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor: pops the scoreboard on every issued pixel.
    always @(negedge clk) begin
        cyc++;
        if (pool_ena) begin
            ena_cnt++;
            run++;
            check("ena_excl", int'({pool_frame_start, pool_line_start, pool_frame_end}), 0);
            if (exp_q.size() == 0) check("data_unexpected", int'(pool_data), -1);
            else check("pool_data", int'(pool_data), exp_q.pop_front());
        end else if (run != 0) begin
            check("pair_len", run, 2);
            run = 0;
        end
        if (pool_frame_start) begin fs_cnt++; fs_cyc = cyc; end
        if (pool_line_start)  ls_cnt++;
        if (pool_frame_end)   begin fe_cnt++; fe_cyc = cyc; end
        if (done)             done_cnt++;
        if (cfg_err)          err_cnt++;
    end

    task automatic start_frame(input int w, input int h);
        cfg_width  = CW'(w);
        cfg_height = RW'(h);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input int d, input int stall);
        bit rdy;
        rdy = 1'b0;
        if (stall > 0) begin
            up.s_valid = 1'b0;
            repeat (stall) begin @(posedge clk); #1; end
        end
        up.s_valid = 1'b1;
        up.s_data  = DATA_W'(d);
        for (int n = 0; n < 100 && !rdy; n++) begin
            @(negedge clk);
            rdy = up.s_ready;
            @(posedge clk); #1;
        end
        up.s_valid = 1'b0;
        if (rdy) exp_q.push_back(d);
        else check("hs_timeout", 0, 1);
    endtask

    task automatic wait_fe(input int f0);
        int n;
        n = 0;
        while (fe_cnt == f0 && n < 300) begin
            @(negedge clk); #1;
            n++;
        end
        if (fe_cnt == f0) check("fe_timeout", 0, 1);
    endtask

    task automatic run_frame(input int w, input int h, input int stall_at,
                             input int mid_at, input int exp_span, input string tag);
        int e0, l0, d0, f0, s0;
        e0 = ena_cnt; l0 = ls_cnt; d0 = done_cnt; f0 = fe_cnt; s0 = fs_cnt;
        start_frame(w, h);
        check({tag, "_busy"}, int'(busy), 1);
        for (int i = 0; i < w * h; i++) begin
            if (i == mid_at) begin
                cfg_width = CW'(8);
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
            send(pix_id, (i == stall_at) ? 3 : 0);
            pix_id++;
        end
        wait_fe(f0);
        check({tag, "_span"}, fe_cyc - fs_cyc + 1, exp_span);
        check({tag, "_ena"}, ena_cnt - e0, w * h);
        check({tag, "_lines"}, ls_cnt - l0, h);
        check({tag, "_done"}, done_cnt - d0, 1);
        check({tag, "_sof"}, fs_cnt - s0, 1);
        @(negedge clk); #1;
        check({tag, "_idle"}, int'(busy), 0);
        check({tag, "_drained"}, exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int e0, l0, d0, f0, s0, r0;
        up.s_valid = 1'b0;
        up.s_data  = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_s_ready", int'(up.s_ready), 0);
        check("rst_ena", int'(pool_ena), 0);
        check("rst_data", int'(pool_data), 0);
        check("rst_pulses", int'({pool_frame_start, pool_line_start, pool_frame_end}), 0);
        check("rst_flags", int'({busy, done, cfg_err}), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Nominal 4x2, then the same frame with a 3-cycle stall inside a pair
        run_frame(4, 2, -1, -1, 23, "f4x2");
        run_frame(4, 2, 1, -1, 26, "stall");

        // Rejected configurations
        e0 = ena_cnt; s0 = fs_cnt; r0 = err_cnt;
        for (int k = 0; k < 3; k++) begin
            int w, h;
            w = (k == 0) ? 5 : ((k == 1) ? 0 : 4);
            h = (k == 2) ? 35 : 2;
            start_frame(w, h);
            @(negedge clk);
            check("cfg_err_pulse", int'(cfg_err), 1);
            check("cfg_err_busy", int'(busy), 0);
            @(posedge clk); #1;
        end
        @(negedge clk); #1;
        check("cfg_err_cleared", int'(cfg_err), 0);
        check("cfg_err_count", err_cnt - r0, 3);
        check("cfg_err_no_ena", ena_cnt - e0, 0);
        check("cfg_err_no_sof", fs_cnt - s0, 0);
        @(posedge clk); #1;

        // Abort in ISS1 of row 1 of a 4x4 frame
        e0 = ena_cnt; l0 = ls_cnt; d0 = done_cnt; f0 = fe_cnt;
        start_frame(4, 4);
        for (int i = 0; i < 6; i++) begin
            send(pix_id, 0);
            pix_id++;
        end
        @(posedge clk); #1;
        check("abort_at_iss1", int'(pool_ena), 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_fe", int'(pool_frame_end), 1);
        check("abort_no_done", int'(done), 0);
        check("abort_eof_busy", int'(busy), 1);
        check("abort_eof_ena", int'(pool_ena), 0);
        @(posedge clk); #1;
        check("abort_idle", int'(busy), 0);
        check("abort_fe_single", int'(pool_frame_end), 0);
        @(negedge clk); #1;
        check("abort_ena_total", ena_cnt - e0, 6);
        check("abort_lines", ls_cnt - l0, 2);
        check("abort_done_total", done_cnt - d0, 0);
        check("abort_fe_total", fe_cnt - f0, 1);
        @(posedge clk); #1;
        run_frame(4, 2, -1, -1, 23, "post_abort");

        // Width change and a stray start mid-frame are ignored
        run_frame(4, 2, -1, 2, 23, "midcfg");

        // Reset pulse while in GAP
        f0 = fe_cnt;
        start_frame(4, 2);
        for (int i = 0; i < 4; i++) begin
            send(pix_id, 0);
            pix_id++;
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("gap_busy", int'(busy), 1);
        check("gap_no_ena", int'(pool_ena), 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rstgap_s_ready", int'(up.s_ready), 0);
        check("rstgap_outputs", int'({pool_ena, pool_frame_start, pool_line_start,
                                      pool_frame_end, busy, done, cfg_err}), 0);
        check("rstgap_data", int'(pool_data), 0);
        repeat (4) begin @(negedge clk); #1; end
        check("rstgap_no_fe", fe_cnt - f0, 0);
        check("rstgap_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
